// File: rtl/gcm_tag_verifier_pkg.sv
// -----------------------------------------------------------------------------
// gcm_tag_verifier_pkg
//   Shared definitions for the AES-GCM receive-side tag verifier:
//   FSM state encoding, default block width, the captured-item flag struct,
//   the verdict struct and the tag-width legality check.
// -----------------------------------------------------------------------------
package gcm_tag_verifier_pkg;

   localparam int NB_BLOCK_DEF = 128;
   localparam int NB_FAIL_CNT  = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_CHECK   = 2'd2
   } state_t;

   // One flag per item collected for a frame
   typedef struct packed {
      logic ekj0;
      logic ghash;
      logic tag;
   } items_t;

   // Verdict qualifiers, registered alongside o_valid
   typedef struct packed {
      logic ok;
      logic fail;
      logic timeout;
      logic abort;
   } verdict_t;

   // Legal received-tag widths: 96..128 bits in whole bytes, never wider than the block
   function automatic bit tag_width_ok(input int nb_tag, input int nb_block);
      return (nb_tag >= 96) && (nb_tag <= 128) && (nb_tag <= nb_block) && ((nb_tag % 8) == 0);
   endfunction

endpackage

// File: rtl/gcm_tag_verifier_compare.sv
// -----------------------------------------------------------------------------
// gcm_tag_compare
//   Combinational tag check: tag_calc = ekj0 ^ ghash, truncated to its upper
//   NB_TAG bits, compared against the received tag by a full-width
//   XOR / OR-reduce (constant depth, no early exit on the first differing bit).
// Ports
//   ekj0   [NB_BLOCK] E(K,J0)
//   ghash  [NB_BLOCK] final GHASH value
//   tag_rx [NB_TAG]   received tag
//   match             1 when the truncated computed tag equals tag_rx
// -----------------------------------------------------------------------------
module gcm_tag_compare
   import gcm_tag_verifier_pkg::*;
#(
   parameter int NB_BLOCK = NB_BLOCK_DEF,
   parameter int NB_TAG   = 128
) (
   input  logic [NB_BLOCK-1:0] ekj0,
   input  logic [NB_BLOCK-1:0] ghash,
   input  logic [NB_TAG-1:0]   tag_rx,
   output logic                match
);

   logic [NB_BLOCK-1:0] tag_calc;
   logic [NB_TAG-1:0]   diff;

   assign tag_calc = ekj0 ^ ghash;
   assign diff     = tag_calc[NB_BLOCK-1 -: NB_TAG] ^ tag_rx;
   assign match    = ~(|diff);

   // Truncated tags drop the low bits of the computed tag
   generate
      if (NB_TAG < NB_BLOCK) begin : g_trunc
         logic unused_low;
         assign unused_low = ^tag_calc[NB_BLOCK-NB_TAG-1:0];
      end
   endgenerate

endmodule

// File: rtl/gcm_tag_verifier.sv
// -----------------------------------------------------------------------------
// gcm_tag_verifier
//   Decrypt-side AES-GCM tag verifier. Collects E(K,J0), the final GHASH and
//   the received tag for a frame (any order, first capture wins), then emits
//   a single registered pass/fail verdict strobe.
//
// Ports
//   i_clock, i_reset        clock, asynchronous active-high reset
//   i_sop                   start of frame; mid-frame it aborts the old frame
//   i_ekj0 / _valid         E(K,J0) from the GCTR pre-block pass
//   i_ghash / _valid        final GHASH(H, A, C)
//   i_tag_rx / _valid       received tag (NB_TAG bits)
//   i_rf_timeout            max COLLECT cycles, 0 disables the timeout
//   o_valid                 one-cycle verdict strobe
//   o_tag_ok / o_tag_fail   verdict, qualified by o_valid
//   o_timeout / o_abort     failure cause, qualified by o_valid
//   o_busy                  FSM outside IDLE
//   o_fail_count            (GCM_TAG_VERIFIER_FAIL_CNT_EN only) saturating
//                           count of o_tag_fail strobes
//
// Build option: define GCM_TAG_VERIFIER_FAIL_CNT_EN to add o_fail_count.
//
// Timing: last item in cycle N, CHECK in N+1, verdict in N+2. Timeout and
// abort verdicts land one cycle after the triggering cycle.
// -----------------------------------------------------------------------------
module gcm_tag_verifier
   import gcm_tag_verifier_pkg::*;
#(
   parameter int NB_BLOCK = NB_BLOCK_DEF,
   parameter int NB_TAG   = 128,
   parameter int NB_TIMER = 16
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_sop,
   input  logic [NB_BLOCK-1:0] i_ekj0,
   input  logic                i_ekj0_valid,
   input  logic [NB_BLOCK-1:0] i_ghash,
   input  logic                i_ghash_valid,
   input  logic [NB_TAG-1:0]   i_tag_rx,
   input  logic                i_tag_rx_valid,
   input  logic [NB_TIMER-1:0] i_rf_timeout,
   output logic                o_valid,
   output logic                o_tag_ok,
   output logic                o_tag_fail,
   output logic                o_timeout,
   output logic                o_abort,
   output logic                o_busy
`ifdef GCM_TAG_VERIFIER_FAIL_CNT_EN
   ,
   output logic [NB_FAIL_CNT-1:0] o_fail_count
`endif
);

   generate
      if (!tag_width_ok(NB_TAG, NB_BLOCK)) begin : g_bad_tag_width
         $error("gcm_tag_verifier: NB_TAG must be 96..128 in steps of 8 and <= NB_BLOCK");
      end
   endgenerate

   state_t              state;
   items_t              flags;
   logic [NB_TIMER-1:0] timer;

   // Captured items; never cleared, only the flags say whether they belong
   // to the current frame
   logic [NB_BLOCK-1:0] ekj0_q;
   logic [NB_BLOCK-1:0] ghash_q;
   logic [NB_TAG-1:0]   tag_q;

   logic                cap_en;
   items_t              held;
   items_t              take;
   items_t              have;
   logic [NB_TIMER-1:0] timer_inc;
   logic                timer_hit;
   logic                match;
   logic                vld_next;
   verdict_t            verdict_next;

   // ---------------------------------------------------------------------------
   // Capture qualification
   // ---------------------------------------------------------------------------
   always_comb begin
      cap_en = (state == ST_COLLECT) || ((state == ST_IDLE) && i_sop);
      // A sop opens a new frame, so flags from the old one no longer count;
      // this lets same-cycle strobes land in the new frame after an abort.
      held = ((state == ST_COLLECT) && !i_sop) ? flags : '0;

      take.ekj0  = cap_en && i_ekj0_valid   && !held.ekj0;
      take.ghash = cap_en && i_ghash_valid  && !held.ghash;
      take.tag   = cap_en && i_tag_rx_valid && !held.tag;

      have = held | take;

      // Counter holds the number of COLLECT cycles already completed, so the
      // match fires at the end of the i_rf_timeout-th COLLECT cycle.
      timer_inc = timer + NB_TIMER'(1);
      timer_hit = (state == ST_COLLECT) && (i_rf_timeout != '0) && (timer_inc == i_rf_timeout);
   end

   always_ff @(posedge i_clock) begin
      if (take.ekj0)  ekj0_q  <= i_ekj0;
      if (take.ghash) ghash_q <= i_ghash;
      if (take.tag)   tag_q   <= i_tag_rx;
   end

   gcm_tag_compare #(
      .NB_BLOCK (NB_BLOCK),
      .NB_TAG   (NB_TAG)
   ) u_compare (
      .ekj0   (ekj0_q),
      .ghash  (ghash_q),
      .tag_rx (tag_q),
      .match  (match)
   );

   // ---------------------------------------------------------------------------
   // Verdict selection. Abort outranks timeout (the new sop always starts a
   // frame); timeout outranks an item completing in the same cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      vld_next     = 1'b0;
      verdict_next = '0;
      case (state)
         ST_COLLECT: begin
            if (i_sop) begin
               vld_next             = 1'b1;
               verdict_next.fail    = 1'b1;
               verdict_next.abort   = 1'b1;
            end else if (timer_hit) begin
               vld_next             = 1'b1;
               verdict_next.fail    = 1'b1;
               verdict_next.timeout = 1'b1;
            end
         end
         ST_CHECK: begin
            vld_next          = 1'b1;
            verdict_next.ok   = match;
            verdict_next.fail = ~match;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state      <= ST_IDLE;
         flags      <= '0;
         timer      <= '0;
         o_valid    <= 1'b0;
         o_tag_ok   <= 1'b0;
         o_tag_fail <= 1'b0;
         o_timeout  <= 1'b0;
         o_abort    <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         o_valid    <= vld_next;
         o_tag_ok   <= verdict_next.ok;
         o_tag_fail <= verdict_next.fail;
         o_timeout  <= verdict_next.timeout;
         o_abort    <= verdict_next.abort;

         case (state)
            ST_IDLE: begin
               if (i_sop) begin
                  state  <= ST_COLLECT;
                  flags  <= have;
                  timer  <= '0;
                  o_busy <= 1'b1;
               end else begin
                  flags  <= '0;
                  o_busy <= 1'b0;
               end
            end

            ST_COLLECT: begin
               if (i_sop) begin
                  // Abort: restart collection for the new frame, stay busy
                  flags  <= have;
                  timer  <= '0;
                  o_busy <= 1'b1;
               end else if (timer_hit) begin
                  state  <= ST_IDLE;
                  flags  <= '0;
                  o_busy <= 1'b0;
               end else if (&have) begin
                  state  <= ST_CHECK;
                  flags  <= have;
                  timer  <= timer_inc;
                  o_busy <= 1'b1;
               end else begin
                  flags  <= have;
                  timer  <= timer_inc;
                  o_busy <= 1'b1;
               end
            end

            ST_CHECK: begin
               state  <= ST_IDLE;
               flags  <= '0;
               o_busy <= 1'b0;
            end

            default: begin
               state  <= ST_IDLE;
               flags  <= '0;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef GCM_TAG_VERIFIER_FAIL_CNT_EN
   // Counts fail strobes on the same edge that registers o_tag_fail
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_fail_count <= '0;
      end else if (verdict_next.fail && (o_fail_count != '1)) begin
         o_fail_count <= o_fail_count + NB_FAIL_CNT'(1);
      end
   end
`endif

endmodule

// File: tb/tb_gcm_tag_verifier.sv
// Table-driven bench for gcm_tag_verifier: a 128-bit-tag instance and a
// 96-bit-tag instance share stimulus; the 96-bit one sees the upper 96 bits
// of the driven tag.
module tb_gcm_tag_verifier;

   localparam logic [127:0] EKJ0  = 128'h530f8afbc74536b9a963b4f1c4cb738b;
   localparam logic [127:0] GHASH = 128'h83de425c5edc5d498f382c441041ca92;
   localparam logic [127:0] TAG   = 128'hd0d1c8a799996bf0265b98b5d48ab919;
   localparam logic [127:0] JUNK  = 128'hdeadbeef_0badf00d_cafebabe_12345678;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, sop, ekj0_v, ghash_v, tag_v;
   logic [127:0] ekj0, ghash, tag;
   logic [95:0]  tag96;
   logic [15:0]  tmo;
   logic         valid, ok, fail, tout, abrt, busy;
   logic         valid96, ok96, fail96, tout96, abrt96, busy96;
`ifdef GCM_TAG_VERIFIER_FAIL_CNT_EN
   logic [15:0]  fcnt, fcnt96;
`endif

   assign tag96 = tag[127:32];

   gcm_tag_verifier #(.NB_BLOCK(128), .NB_TAG(128), .NB_TIMER(16)) dut (
      .i_clock(clk), .i_reset(rst), .i_sop(sop),
      .i_ekj0(ekj0), .i_ekj0_valid(ekj0_v),
      .i_ghash(ghash), .i_ghash_valid(ghash_v),
      .i_tag_rx(tag), .i_tag_rx_valid(tag_v),
      .i_rf_timeout(tmo),
      .o_valid(valid), .o_tag_ok(ok), .o_tag_fail(fail),
      .o_timeout(tout), .o_abort(abrt), .o_busy(busy)
`ifdef GCM_TAG_VERIFIER_FAIL_CNT_EN
      , .o_fail_count(fcnt)
`endif
   );

   gcm_tag_verifier #(.NB_BLOCK(128), .NB_TAG(96), .NB_TIMER(16)) dut96 (
      .i_clock(clk), .i_reset(rst), .i_sop(sop),
      .i_ekj0(ekj0), .i_ekj0_valid(ekj0_v),
      .i_ghash(ghash), .i_ghash_valid(ghash_v),
      .i_tag_rx(tag96), .i_tag_rx_valid(tag_v),
      .i_rf_timeout(tmo),
      .o_valid(valid96), .o_tag_ok(ok96), .o_tag_fail(fail96),
      .o_timeout(tout96), .o_abort(abrt96), .o_busy(busy96)
`ifdef GCM_TAG_VERIFIER_FAIL_CNT_EN
      , .o_fail_count(fcnt96)
`endif
   );

   typedef struct {
      logic [127:0] ekj0;
      logic [127:0] ghash;
      logic [127:0] tag;
      logic         ok128;
      logic         ok96;
   } vec_t;

   vec_t vecs [6];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_f128 = 0;
   int   exp_f96  = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      sop = 1'b0; ekj0_v = 1'b0; ghash_v = 1'b0; tag_v = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; tmo = '0;
      ekj0 = '0; ghash = '0; tag = '0;
      idle_inputs();

      vecs[0] = '{EKJ0, GHASH, TAG,                         1'b1, 1'b1};
      vecs[1] = '{EKJ0, GHASH, TAG ^ 128'd1,                1'b0, 1'b1};
      vecs[2] = '{EKJ0, GHASH, TAG ^ 128'hffffffff,         1'b0, 1'b1};
      vecs[3] = '{EKJ0, GHASH, TAG ^ (128'd1 << 32),        1'b0, 1'b0};
      vecs[4] = '{EKJ0, GHASH, TAG ^ (128'd1 << 127),       1'b0, 1'b0};
      vecs[5] = '{128'd0, JUNK, JUNK,                        1'b1, 1'b1};

      // ---- reset state ----
      tick(); tick();
      chk1("rst_valid", valid, 1'b0);
      chk1("rst_ok",    ok,    1'b0);
      chk1("rst_fail",  fail,  1'b0);
      chk1("rst_tout",  tout,  1'b0);
      chk1("rst_abort", abrt,  1'b0);
      chk1("rst_busy",  busy,  1'b0);
      rst = 1'b0;
      tick(); tick();

      // ---- table: sop, ekj0, ghash, tag on consecutive cycles ----
      for (int i = 0; i < 6; i++) begin
         sop = 1'b1;
         tick(); sop = 1'b0; ekj0 = vecs[i].ekj0; ekj0_v = 1'b1;
         tick(); ekj0_v = 1'b0; ghash = vecs[i].ghash; ghash_v = 1'b1;
         tick(); ghash_v = 1'b0; tag = vecs[i].tag; tag_v = 1'b1;
         tick(); tag_v = 1'b0;
         chk1($sformatf("v%0d_check_valid", i), valid, 1'b0);
         chk1($sformatf("v%0d_check_busy", i),  busy,  1'b1);
         tick();
         chk1($sformatf("v%0d_valid", i),   valid,   1'b1);
         chk1($sformatf("v%0d_ok", i),      ok,      vecs[i].ok128);
         chk1($sformatf("v%0d_fail", i),    fail,    ~vecs[i].ok128);
         chk1($sformatf("v%0d_tout", i),    tout,    1'b0);
         chk1($sformatf("v%0d_abort", i),   abrt,    1'b0);
         chk1($sformatf("v%0d_busy", i),    busy,    1'b0);
         chk1($sformatf("v%0d_valid96", i), valid96, 1'b1);
         chk1($sformatf("v%0d_ok96", i),    ok96,    vecs[i].ok96);
         chk1($sformatf("v%0d_fail96", i),  fail96,  ~vecs[i].ok96);
         if (!vecs[i].ok128) exp_f128++;
         if (!vecs[i].ok96)  exp_f96++;
         tick();
         chk1($sformatf("v%0d_strobe_end", i), valid, 1'b0);
      end

      // ---- reversed order plus duplicate ghash carrying garbage ----
      sop = 1'b1;
      tick(); sop = 1'b0; tag = TAG; tag_v = 1'b1;
      tick(); tag_v = 1'b0; ghash = GHASH; ghash_v = 1'b1;
      tick(); ghash = JUNK;
      chk1("rev_busy", busy, 1'b1);
      tick(); ghash_v = 1'b0; ekj0 = EKJ0; ekj0_v = 1'b1;
      tick(); ekj0_v = 1'b0;
      chk1("rev_check_valid", valid, 1'b0);
      tick();
      chk1("rev_valid", valid,   1'b1);
      chk1("rev_ok",    ok,      1'b1);
      chk1("rev_ok96",  ok96,    1'b1);
      tick();

      // ---- timeout: ghash never arrives ----
      tmo = 16'd5;
      sop = 1'b1;
      tick(); sop = 1'b0; ekj0 = EKJ0; ekj0_v = 1'b1;
      chk1("tmo_c1_valid", valid, 1'b0);
      tick(); ekj0_v = 1'b0; tag = TAG; tag_v = 1'b1;
      chk1("tmo_c2_valid", valid, 1'b0);
      tick(); tag_v = 1'b0;
      for (int c = 3; c <= 5; c++) begin
         chk1($sformatf("tmo_c%0d_valid", c), valid, 1'b0);
         chk1($sformatf("tmo_c%0d_busy", c),  busy,  1'b1);
         tick();
      end
      chk1("tmo_valid", valid, 1'b1);
      chk1("tmo_fail",  fail,  1'b1);
      chk1("tmo_ok",    ok,    1'b0);
      chk1("tmo_tout",  tout,  1'b1);
      chk1("tmo_abort", abrt,  1'b0);
      chk1("tmo_busy",  busy,  1'b0);
      chk1("tmo_tout96", tout96, 1'b1);
      exp_f128++; exp_f96++;
      tick();
      chk1("tmo_after_valid", valid, 1'b0);
      chk1("tmo_after_busy",  busy,  1'b0);
      tmo = 16'd0;

      // ---- abort: second sop after two items; same-cycle ekj0 is new frame ----
      sop = 1'b1;
      tick(); sop = 1'b0; ekj0 = JUNK; ekj0_v = 1'b1;
      tick(); ekj0_v = 1'b0; ghash = JUNK; ghash_v = 1'b1;
      tick(); ghash_v = 1'b0; sop = 1'b1; ekj0 = EKJ0; ekj0_v = 1'b1;
      tick(); sop = 1'b0; ekj0_v = 1'b0; ghash = GHASH; ghash_v = 1'b1;
      chk1("abort_valid", valid, 1'b1);
      chk1("abort_fail",  fail,  1'b1);
      chk1("abort_flag",  abrt,  1'b1);
      chk1("abort_tout",  tout,  1'b0);
      chk1("abort_ok",    ok,    1'b0);
      chk1("abort_busy",  busy,  1'b1);
      exp_f128++; exp_f96++;
      tick(); ghash_v = 1'b0; tag = TAG; tag_v = 1'b1;
      chk1("abort_c5_valid", valid, 1'b0);
      tick(); tag_v = 1'b0;
      chk1("abort_c6_valid", valid, 1'b0);
      tick();
      chk1("abort_new_valid", valid, 1'b1);
      chk1("abort_new_ok",    ok,    1'b1);
      chk1("abort_new_abort", abrt,  1'b0);
      tick();

`ifdef GCM_TAG_VERIFIER_FAIL_CNT_EN
      chk16("fail_count",   fcnt,   16'(exp_f128));
      chk16("fail_count96", fcnt96, 16'(exp_f96));
`endif

      // ---- reset mid-COLLECT ----
      sop = 1'b1;
      tick(); sop = 1'b0; ekj0 = EKJ0; ekj0_v = 1'b1;
      tick(); ekj0_v = 1'b0; ghash = GHASH; ghash_v = 1'b1;
      tick(); ghash_v = 1'b0;
      chk1("mid_busy_before", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk1("mid_rst_busy",  busy,  1'b0);
      chk1("mid_rst_valid", valid, 1'b0);
      tick(); rst = 1'b0; tag = TAG; tag_v = 1'b1;
      tick(); tag_v = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk1($sformatf("mid_no_verdict_%0d", c), valid, 1'b0);
         chk1($sformatf("mid_idle_busy_%0d", c),  busy,  1'b0);
         tick();
      end
`ifdef GCM_TAG_VERIFIER_FAIL_CNT_EN
      chk16("fail_count_rst", fcnt, 16'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gcm_tag_verifier.md
# gcm_tag_verifier

Receive-side companion to the GCTR datapath. It closes the decrypt direction of AES-GCM by collecting three items per frame: E(K,J0) from the GCTR pre-block pass, the final GHASH value, and the received tag from the frame trailer. It forms the computed tag, compares it against the received tag, and reports a single pass/fail verdict per frame. It sits after the GCTR and GHASH cores and before the frame-release logic.

## Interface
- NB_BLOCK, 128, AES block / GHASH width.
- NB_TAG, 128, received tag width; legal values 96..128 in steps of 8.
- NB_TIMER, 16, width of the collection timeout counter.
- i_clock  in  1  single clock.
- i_reset  in  1  reset, asynchronous and active-high.
- i_sop  in  1  start of frame; opens a collection window.
- i_ekj0  in  NB_BLOCK  E(K,J0) from the GCTR pre-block pass.
- i_ekj0_valid  in  1  qualifies i_ekj0.
- i_ghash  in  NB_BLOCK  final GHASH(H, A, C) value.
- i_ghash_valid  in  1  qualifies i_ghash.
- i_tag_rx  in  NB_TAG  received tag.
- i_tag_rx_valid  in  1  qualifies i_tag_rx.
- i_rf_timeout  in  NB_TIMER  maximum number of COLLECT cycles; 0 disables the timeout.
- o_valid  out  1  one-cycle verdict strobe.
- o_tag_ok  out  1  tag matched; meaningful only while o_valid is high.
- o_tag_fail  out  1  mismatch, timeout, or abort; meaningful only while o_valid is high.
- o_timeout  out  1  the failure was caused by the timeout.
- o_abort  out  1  the failure was caused by a new i_sop arriving mid-frame.
- o_busy  out  1  high while the FSM is outside IDLE.

## Operation
- FSM states: IDLE, COLLECT, CHECK.
  - IDLE -> COLLECT on i_sop.
  - COLLECT -> CHECK when all three capture flags are set.
  - CHECK -> IDLE unconditionally.
- Capture:
  - Each item is registered on its valid strobe, and the matching flag is set.
  - Capture is accepted in COLLECT, and also in the IDLE cycle where i_sop is high.
  - Arrival order is free.
  - First capture wins: a repeat strobe for an item whose flag is already set is ignored.
  - Strobes seen in IDLE without i_sop, or in CHECK, are ignored.
- Tag arithmetic:
  - tag_calc = ekj0 XOR ghash.
  - Compare tag_calc[NB_BLOCK-1 -: NB_TAG] (MSB truncation) against i_tag_rx.
  - The comparison is a full-width XOR-reduce, with no early-exit.
- Timeout:
  - The counter clears on entry to COLLECT and increments every COLLECT cycle.
  - When it equals i_rf_timeout (with i_rf_timeout != 0), the block pulses o_valid with o_tag_fail=1 and o_timeout=1, then goes to IDLE.
- Abort:
  - An i_sop in COLLECT pulses o_valid with o_tag_fail=1 and o_abort=1 for the old frame.
  - The flags clear and the FSM stays in COLLECT for the new frame.
  - Strobes in that same cycle belong to the new frame.
- If the last item arrives in the same cycle as the timeout match, the timeout wins.
- Captured data registers are not cleared between frames; only the flags clear.
- Reset, including mid-frame: FSM to IDLE, flags and counter to 0, and every output to 0. No verdict is emitted for the interrupted frame.

## Timing
- The last item is presented in cycle N. CHECK occupies cycle N+1. o_valid, together with o_tag_ok or o_tag_fail, is high in cycle N+2 for exactly one cycle.
- Timeout and abort verdicts appear in the cycle after the triggering condition.
- All outputs are registered.
- o_tag_ok and o_tag_fail are never both high.
- o_busy falls in the cycle o_valid rises, except after an abort, where it stays high.

## Configuration
- GCM_TAG_VERIFIER_FAIL_CNT_EN:
  - Defined: adds output o_fail_count (16 bit). It is a saturating count of o_tag_fail strobes, reset to 0, and holds at 0xFFFF.
  - Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared GCM package:
  - FSM state encoding (2 bit).
  - NB_BLOCK default.
  - Tag-width legality check constant.
- Natural sub-module: gcm_tag_compare. It is the combinational truncate-XOR-reduce, instantiated once, and has its output registered in CHECK.

## Test plan
- Pass case (NIST GCM test case 14 values):
  - Stimulus: i_sop, then ekj0, ghash, and the correct 128-bit tag on consecutive cycles.
  - Response: o_valid with o_tag_ok=1 two cycles after the tag.
- Fail case:
  - Stimulus: same vectors with tag bit 0 flipped.
  - Response: o_tag_fail=1, o_timeout=0, o_abort=0.
- Arrival order and duplicates:
  - Stimulus: reversed order (tag, ghash, ekj0), then a duplicate ghash with garbage data.
  - Response: verdict unchanged (ok); the duplicate is ignored.
- Truncated tag:
  - Stimulus: NB_TAG=96, received tag = upper 96 bits of the correct tag.
  - Response: o_tag_ok=1. The same with the low 32 bits of the full tag corrupted is also ok.
- Timeout:
  - Stimulus: i_rf_timeout=5, ghash never sent.
  - Response: o_valid with o_tag_fail=1 and o_timeout=1 in the sixth cycle after sop, then IDLE.
- Abort and reset:
  - Stimulus: second i_sop after two items.
  - Response: o_abort verdict, then the new frame verifies correctly.
  - Stimulus: i_reset asserted mid-COLLECT.
  - Response: all outputs 0 immediately and no verdict emitted.
